// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: burst write controller for the write side of an async FIFO
module fifo_wr_ctrl #(
  parameter int SIZE  = 3,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          wr_clk,
  input  logic          wr_rstn,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          full,
  input  logic [SIZE:0] bi_wr_ptr,
  input  logic [SIZE:0] gr_rd_ptr,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic [SIZE:0] wr_level,
  output logic          almost_full,
  output logic          burst_done
);
  localparam int DEPTH_I = 1 << SIZE;
  localparam int THR_I   = DEPTH_I - BURST;
  localparam int LAST_I  = BURST - 1;
  localparam logic [SIZE:0] DEPTH = DEPTH_I[SIZE:0];
  localparam logic [SIZE:0] BLEN  = BURST[SIZE:0];
  localparam logic [SIZE:0] THR   = THR_I[SIZE:0];
  localparam logic [SIZE:0] LAST  = LAST_I[SIZE:0];
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [SIZE:0] sync1, sync2, rd_bin, level_nxt, free, burst_cnt;
  logic [1:0]    state, state_nxt;
  logic          last;

  for (genvar i = 0; i <= SIZE; i++) begin : g_g2b
    assign rd_bin[i] = ^sync2[SIZE:i];
  end

  // a stale read pointer only makes free look smaller, never larger
  assign level_nxt  = bi_wr_ptr - rd_bin;
  assign free       = DEPTH - wr_level;
  assign s_ready    = (state == S_BURST) && !full;
  assign wr_en      = s_valid && s_ready;
  assign wr_data    = s_data;
  assign burst_done = state == S_GAP;
  assign last       = wr_en && (burst_cnt == LAST);

  always_comb
    state_nxt = (state == S_IDLE)  ? ((s_valid && free >= BLEN) ? S_BURST : S_IDLE) :
                (state == S_BURST) ? (last ? S_GAP : S_BURST) : S_IDLE;

  always_ff @(posedge wr_clk or negedge wr_rstn)
    if (!wr_rstn) begin
      sync1       <= '0;
      sync2       <= '0;
      wr_level    <= '0;
      almost_full <= 1'b0;
      state       <= S_IDLE;
      burst_cnt   <= '0;
    end else begin
      sync1       <= gr_rd_ptr;
      sync2       <= sync1;
      wr_level    <= level_nxt;
      almost_full <= level_nxt > THR;
      state       <= state_nxt;
      burst_cnt   <= (state != S_BURST) ? '0 : burst_cnt + {{SIZE{1'b0}}, wr_en};
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 3, meaning FIFO depth is 2^SIZE entries and pointers are SIZE+1 bits.
REQ-002 SHALL have parameter DW, default 8, meaning the data width.
REQ-003 SHALL have parameter BURST, default 4, meaning words per write burst; legal range 1..2^SIZE.
REQ-004 SHALL have port wr_clk, input, 1, write-domain clock.
REQ-005 SHALL have port wr_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port s_valid, input, 1, upstream word valid.
REQ-007 SHALL have port s_data, input, DW, upstream word.
REQ-008 SHALL have port s_ready, output, 1, upstream word accepted this cycle when s_valid is also 1.
REQ-009 SHALL have port full, input, 1, registered full flag from the write-pointer logic.
REQ-010 SHALL have port bi_wr_ptr, input, SIZE+1, binary write pointer from the write-pointer logic.
REQ-011 SHALL have port gr_rd_ptr, input, SIZE+1, gray read pointer, asynchronous to wr_clk.
REQ-012 SHALL have port wr_en, output, 1, FIFO write strobe.
REQ-013 SHALL have port wr_data, output, DW, FIFO write data.
REQ-014 SHALL have port wr_level, output, SIZE+1, registered fill level as seen from the write domain.
REQ-015 SHALL have port almost_full, output, 1, registered; 1 when wr_level > 2^SIZE - BURST.
REQ-016 SHALL have port burst_done, output, 1, one-cycle pulse when a burst completes.

Function
REQ-017 SHALL synchronize gr_rd_ptr through two wr_clk flops (sync1, sync2); no other logic SHALL sample gr_rd_ptr.
REQ-018 SHALL convert sync2 from gray to binary combinationally: rd_bin[SIZE] = sync2[SIZE]; rd_bin[i] = rd_bin[i+1] XOR sync2[i].
REQ-019 SHALL register wr_level <= (bi_wr_ptr - rd_bin) modulo 2^(SIZE+1). A gr_rd_ptr change is visible on wr_level after the 3rd wr_clk edge.
REQ-020 SHALL define free = 2^SIZE - wr_level, computed combinationally. Staleness of the read pointer only underestimates free, and this is acceptable.
REQ-021 SHALL implement FSM states IDLE, BURST and GAP.
  - IDLE -> BURST when s_valid=1 and free >= BURST; otherwise stay in IDLE.
  - BURST -> GAP on the cycle the BURST-th word is written.
  - GAP -> IDLE unconditionally after 1 cycle.
REQ-022 SHALL drive s_ready = (state==BURST) AND NOT full, combinationally.
REQ-023 SHALL drive wr_en = s_valid AND s_ready and wr_data = s_data, combinationally, so the write lands on the same edge as the handshake.
REQ-024 SHALL count written words in burst_cnt, clearing it to 0 on entry to BURST.
  - s_valid=0 or full=1 mid-burst: burst_cnt holds and the FSM stays in BURST.
REQ-025 SHALL pulse burst_done=1 for exactly the one cycle the FSM is in GAP.
REQ-026 SHALL never assert wr_en outside BURST or while full=1.

Reset
REQ-027 SHALL, while wr_rstn=0, asynchronously force:
  - state=IDLE;
  - sync1, sync2, burst_cnt, wr_level = 0;
  - almost_full=0 and burst_done=0;
  - s_ready=0 and wr_en=0, which follow from state=IDLE.
REQ-028 SHALL abandon any partial burst on reset; words already written stay counted by bi_wr_ptr.

Verification (SIZE=3, BURST=4)
REQ-029 SHALL cover reset: wr_rstn=0, then released -> wr_en=0, s_ready=0, wr_level=0, almost_full=0, state IDLE.
REQ-030 SHALL cover an empty FIFO, with gr_rd_ptr=0, s_valid held 1 and bi_wr_ptr driven by a wr_ptr model:
  - expected: 4 consecutive wr_en, then burst_done for 1 cycle, then a second burst of 4;
  - expected: wr_level reaches 8 and full=1, the FSM stays in IDLE, and almost_full=1.
REQ-031 SHALL cover level sync: bi_wr_ptr=10 and gr_rd_ptr=4'b0101 (binary 6) from reset -> wr_level=4 after the 3rd edge, almost_full=0; then gr_rd_ptr=4'b0111 (binary 5) -> wr_level=5, almost_full=1.
REQ-032 SHALL cover s_valid=0 for 2 cycles after the 2nd word of a burst -> no wr_en during the gap, burst_cnt holds at 2, and exactly 2 further writes complete the burst.
REQ-033 SHALL cover full=1 forced for 3 cycles mid-burst with s_valid=1 -> s_ready=0 and wr_en=0 for those cycles, and the burst resumes when full=0.
REQ-034 SHALL cover wr_rstn=0 asserted after the 3rd word of a burst -> immediately wr_en=0 and state IDLE; after release, a new burst of 4 starts.
